uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 sender. Adds:
- Configurable data width, parity and stop bits.
- Baud divider derived from parameters.
- Small synchronous TX FIFO so a host can queue bytes while a frame is in flight.

It sits between the host/control logic and the tx pin; `start`/`datain`/`busy`/`tx` keep their existing meaning.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles per bit. Elaboration error if DIV < 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- datain  in  DATA_BITS  word to transmit; sampled on the start rising edge.
- start  in  1  push request; rising-edge detected internally.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while FSM not IDLE or FIFO non-empty.
- full  out  1  FIFO count == FIFO_DEPTH.
- overrun  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (rstn=0 at an edge): tx=1, busy=0, full=0, overrun=0, FIFO emptied, FSM=IDLE, baud and bit counters=0, start-edge register=0.
- Reset mid-frame aborts the frame. tx returns to 1 at that edge.
- Push:
  - push = start & ~start_q (start_q is start registered).
  - Holding start high for N cycles yields exactly one push.
  - Push accepted if !full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overrun=1 for one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If FIFO non-empty at an edge: pop the head into the shift register, go to START, drive tx=0 from that edge.
  - A word pushed at edge N is popped at edge N+1, so tx falls at edge N+1.
- Bit timing: every state other than IDLE holds tx for exactly DIV cycles. The baud counter runs 0..DIV-1 and resets on each state or bit change.
- START -> DATA.
- DATA:
  - Sends DATA_BITS bits, LSB first, one per DIV cycles.
  - Goes to PARITY if PARITY != 0, else to STOP.
- PARITY bit:
  - Even: XOR of the data bits.
  - Odd: inverse of that XOR.
  - Then -> STOP.
- STOP:
  - tx=1 for STOP_BITS*DIV cycles.
  - At the end: if FIFO non-empty, pop and go straight to START with no idle gap; else go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles.
- busy:
  - Combinational from registered state: (state != IDLE) | (count != 0).
  - Rises the cycle after an accepted push.
  - Falls at the edge the last STOP completes with the FIFO empty.
- FIFO:
  - Count width clog2(FIFO_DEPTH)+1.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
- datain and start are don't-care while start is not rising.

Decomposition:
- Package uart_pkg:
  - Parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encoding.
  - clog2 function.
  - Divider computation function.
- Sub-module uart_fifo_sync: parametrised width and depth; push/pop/full/empty/count; synchronous active-low reset.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
All tests use CLK_HZ=50_000_000, BAUD=5_000_000 (DIV=10) and a 20 ns clock.
1. 8N1, single word:
   - Stimulus: push 0x4A with start held 2 cycles.
   - Response: exactly one frame, 100 cycles.
   - tx per 10-cycle slot: 0, 0,1,0,1,0,0,1,0, 1.
   - tx falls 1 cycle after the push edge; busy drops after the stop bit; overrun stays 0.
2. PARITY=2, STOP_BITS=2, push 0x4A:
   - Parity bit = 1; stop high for 20 cycles; frame 120 cycles.
   - Repeat with PARITY=1: parity bit = 0.
3. Back-to-back:
   - Stimulus: push 0x55 then 0xA3 within 10 cycles.
   - Response: second start bit begins the cycle after the first frame's stop bit ends, with no idle gap; total 200 cycles busy.
4. Overrun, FIFO_DEPTH=4:
   - Stimulus: six pushes at edges 0,2,4,6,8,10.
   - Response: first word popped at edge 1; full=1 after edge 8; push at edge 10 dropped with a 1-cycle overrun pulse.
   - Exactly five frames emitted, in push order.
5. Reset mid-frame:
   - Stimulus: rstn=0 for 1 cycle at cycle 45 of the first frame, with 2 words still queued.
   - Response: tx=1 and busy=0 at the next edge; no further frames emitted.
6. DATA_BITS=5, PARITY=0, push 0x1F (upper bits ignored):
   - Frame 70 cycles.
   - tx per slot: 0, 1,1,1,1,1, 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes,
// FSM state encoding and the elaboration-time helper functions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Small synchronous FIFO with a combinational read port; the head word is
// always visible on rdata while the FIFO is non-empty.
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter (configurable data/parity/stop bits) fed by a
// small TX FIFO so the host can queue words while a frame is in flight.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] datain,
    input  logic                 start,
    output logic                 tx,
    output logic                 busy,
    output logic                 full,
    output logic                 overrun
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD);
    localparam int BAUD_W = clog2(DIV);
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: baud divider must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
    end

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   start_q, start_d;
    logic                   overrun_q, overrun_d;

    logic                   push, accept, pop, load, baud_last, head_par;
    logic                   fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic [CNT_W-1:0]       fifo_count;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push      = start & ~start_q;
    assign accept    = ~fifo_full | pop;
    assign start_d   = start;
    assign overrun_d = push & ~accept;

    uart_fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push & accept),
        .wdata (datain),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_par  = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
    assign baud_last = (baud_q == BAUD_W'(DIV - 1));

    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                load = ~fifo_empty;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        load    = ~fifo_empty;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading the head word always starts a fresh frame, from IDLE or straight out of STOP.
        if (load) begin
            state_d = ST_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
            par_d   = head_par;
            tx_d    = 1'b0;
        end
    end

    assign pop = load;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != ST_IDLE) | (fifo_count != '0);
    assign full    = fifo_full;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations share stimulus and each
// test checks the tx waveform of one instance slot by slot.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [8:0] din = '0;

    wire [3:0] tx_w, busy_w, full_w, ovr_w;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(5_000_000)) u_8n1 (
        .clk(clk), .rstn(rstn), .datain(din[7:0]), .start(start),
        .tx(tx_w[0]), .busy(busy_w[0]), .full(full_w[0]), .overrun(ovr_w[0]));

    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .PARITY(2), .STOP_BITS(2)) u_e2 (
        .clk(clk), .rstn(rstn), .datain(din[7:0]), .start(start),
        .tx(tx_w[1]), .busy(busy_w[1]), .full(full_w[1]), .overrun(ovr_w[1]));

    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .PARITY(1), .STOP_BITS(2)) u_o2 (
        .clk(clk), .rstn(rstn), .datain(din[7:0]), .start(start),
        .tx(tx_w[2]), .busy(busy_w[2]), .full(full_w[2]), .overrun(ovr_w[2]));

    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(5)) u_d5 (
        .clk(clk), .rstn(rstn), .datain(din[4:0]), .start(start),
        .tx(tx_w[3]), .busy(busy_w[3]), .full(full_w[3]), .overrun(ovr_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 8N1 slot pattern: start bit, data LSB first, stop bit.
    function automatic logic [15:0] frame_8n1(input logic [7:0] w);
        return {6'b0, 1'b1, w, 1'b0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rstn  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Raise start at the current negedge; returns at the negedge after the push edge.
    task automatic push(input logic [8:0] d, input int hold);
        din   = d;
        start = 1'b1;
        @(negedge clk);
        if (hold > 1) begin
            fork
                begin
                    repeat (hold - 1) @(negedge clk);
                    start = 1'b0;
                end
            join_none
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic run_frame(input int s, input logic [15:0] bits, input int nslots, input string tag);
        logic [9:0] samp;
        logic       busy_all;
        busy_all = 1'b1;
        for (int slot = 0; slot < nslots; slot++) begin
            samp = '0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                samp[c]  = tx_w[s];
                busy_all = busy_all & busy_w[s];
            end
            check($sformatf("%s_slot%0d", tag, slot), {22'b0, samp}, bits[slot] ? 32'h3ff : 32'h0);
        end
        check({tag, "_busy_during"}, {31'b0, busy_all}, 32'h1);
    endtask

    task automatic check_idle(input int s, input string tag);
        @(negedge clk);
        check({tag, "_busy_after"}, {31'b0, busy_w[s]}, 32'h0);
        check({tag, "_tx_after"}, {31'b0, tx_w[s]}, 32'h1);
    endtask

    initial begin
        logic [7:0] words [6];
        logic       acc_tx, acc_busy;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx_w[0]}, 32'h1);
        check("rst_busy", {31'b0, busy_w[0]}, 32'h0);
        check("rst_full", {31'b0, full_w[0]}, 32'h0);
        check("rst_overrun", {31'b0, ovr_w[0]}, 32'h0);
        rstn = 1'b1;

        // Test 1: 8N1 single word, start held for two cycles
        do_reset();
        push(9'h04A, 2);
        check("t1_tx_pre", {31'b0, tx_w[0]}, 32'h1);
        check("t1_busy_rise", {31'b0, busy_w[0]}, 32'h1);
        run_frame(0, 16'h0294, 10, "t1");
        check_idle(0, "t1");
        check("t1_overrun", {31'b0, ovr_w[0]}, 32'h0);
        repeat (20) @(negedge clk);
        check("t1_single_push", {31'b0, busy_w[0]}, 32'h0);

        // Test 2: even and odd parity with two stop bits
        do_reset();
        push(9'h04A, 1);
        fork
            run_frame(1, 16'h0E94, 12, "t2e");
            run_frame(2, 16'h0C94, 12, "t2o");
        join
        fork
            check_idle(1, "t2e");
            check_idle(2, "t2o");
        join

        // Test 3: back-to-back frames with no idle gap
        do_reset();
        push(9'h055, 1);
        fork
            run_frame(0, 16'h02AA, 10, "t3a");
            begin
                repeat (4) @(negedge clk);
                push(9'h0A3, 1);
            end
        join
        run_frame(0, 16'h0346, 10, "t3b");
        check_idle(0, "t3");

        // Test 4: overrun with a four-entry FIFO, pushes at even edges 0..10
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
        do_reset();
        push({1'b0, words[0]}, 1);
        check("t4_tx_pre", {31'b0, tx_w[0]}, 32'h1);
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    run_frame(0, frame_8n1(words[f]), 10, $sformatf("t4_f%0d", f));
                end
            end
            begin
                @(negedge clk);
                check("t4_full_e1", {31'b0, full_w[0]}, 32'h0);
                for (int i = 1; i < 6; i++) begin
                    push({1'b0, words[i]}, 1);
                    if (i == 3) check("t4_full_e6", {31'b0, full_w[0]}, 32'h0);
                    if (i == 4) check("t4_full_e8", {31'b0, full_w[0]}, 32'h1);
                    if (i == 4) check("t4_ovr_e8", {31'b0, ovr_w[0]}, 32'h0);
                    if (i == 5) check("t4_ovr_e10", {31'b0, ovr_w[0]}, 32'h1);
                    @(negedge clk);
                    if (i == 5) check("t4_ovr_e11", {31'b0, ovr_w[0]}, 32'h0);
                end
            end
        join
        check_idle(0, "t4");

        // Test 5: reset at cycle 45 of the first frame with two words queued
        do_reset();
        push(9'h04A, 1);
        @(negedge clk);
        push(9'h0C3, 1);
        @(negedge clk);
        push(9'h03C, 1);
        repeat (41) @(negedge clk);
        check("t5_busy_pre", {31'b0, busy_w[0]}, 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_tx_rst", {31'b0, tx_w[0]}, 32'h1);
        check("t5_busy_rst", {31'b0, busy_w[0]}, 32'h0);
        check("t5_full_rst", {31'b0, full_w[0]}, 32'h0);
        rstn = 1'b1;
        acc_tx   = 1'b1;
        acc_busy = 1'b0;
        repeat (150) begin
            @(negedge clk);
            acc_tx   = acc_tx & tx_w[0];
            acc_busy = acc_busy | busy_w[0];
        end
        check("t5_tx_quiet", {31'b0, acc_tx}, 32'h1);
        check("t5_busy_quiet", {31'b0, acc_busy}, 32'h0);

        // Test 6: five data bits, upper datain bits ignored
        do_reset();
        push(9'h0FF, 1);
        run_frame(3, 16'h007E, 7, "t6");
        check_idle(3, "t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
